// File: rtl/fetch_controller.sv
// Fetch-stage sequencer: owns the fetch PC, captures the two-instruction bundle
// into a one-entry output register toward decode, and handles redirect/fault.
module fetch_controller #(
    parameter int                    ADDR_WIDTH = 32,
    parameter int                    DATA_WIDTH = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC   = '0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    output logic [ADDR_WIDTH-1:0] pc,
    input  logic [ADDR_WIDTH-1:0] fetch_addr_0,
    input  logic [ADDR_WIDTH-1:0] fetch_addr_1,
    input  logic [DATA_WIDTH-1:0] fetch_instr_0,
    input  logic [DATA_WIDTH-1:0] fetch_instr_1,
    input  logic [1:0]            fetch_valid,
    input  logic                  fetch_pred_taken_0,
    input  logic                  fetch_pred_taken_1,
    input  logic [ADDR_WIDTH-1:0] fetch_pred_target_0,
    input  logic [ADDR_WIDTH-1:0] fetch_pred_target_1,
    input  logic                  redirect_valid,
    input  logic [ADDR_WIDTH-1:0] redirect_pc,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr_0,
    output logic [ADDR_WIDTH-1:0] out_addr_1,
    output logic [DATA_WIDTH-1:0] out_instr_0,
    output logic [DATA_WIDTH-1:0] out_instr_1,
    output logic [1:0]            out_instr_valid,
    output logic                  out_pred_taken_0,
    output logic                  out_pred_taken_1,
    output logic [ADDR_WIDTH-1:0] out_pred_target_0,
    output logic [ADDR_WIDTH-1:0] out_pred_target_1,
    output logic                  fetch_fault,
    output logic [31:0]           instr_count
);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FLUSH
    } state_t;

    localparam logic [ADDR_WIDTH-1:0] INSTR_BYTES = ADDR_WIDTH'(4);

    state_t                  state;
    logic                    handshake;
    logic                    capture;
    logic [ADDR_WIDTH-1:0]   next_pc;
    logic [31:0]             delivered;

    assign handshake = out_valid && out_ready;
    assign capture   = (state == RUN) && fetch_valid[0] && (!out_valid || out_ready)
                       && !redirect_valid;
    assign delivered = {31'd0, out_instr_valid[0]} + {31'd0, out_instr_valid[1]};

    // A taken prediction in the youngest valid slot wins; otherwise fall through.
    always_comb begin
        next_pc = pc + INSTR_BYTES;
        if (fetch_valid[1] && fetch_pred_taken_1)
            next_pc = fetch_pred_target_1;
        else if (fetch_valid[1])
            next_pc = fetch_addr_1 + INSTR_BYTES;
        else if (fetch_pred_taken_0)
            next_pc = fetch_pred_target_0;
    end

    // NOTE: all state uses non-blocking assignments so every register samples
    // pre-edge values; the output data registers are reset too, so decode never
    // sees X on a bundle that was never captured.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state             <= IDLE;
            pc                <= RESET_PC;
            out_valid         <= 1'b0;
            out_addr_0        <= '0;
            out_addr_1        <= '0;
            out_instr_0       <= '0;
            out_instr_1       <= '0;
            out_instr_valid   <= '0;
            out_pred_taken_0  <= 1'b0;
            out_pred_taken_1  <= 1'b0;
            out_pred_target_0 <= '0;
            out_pred_target_1 <= '0;
            fetch_fault       <= 1'b0;
            instr_count       <= '0;
        end else begin
            // Counts even when a redirect discards the bundle in the same cycle.
            if (handshake)
                instr_count <= instr_count + delivered;

            case (state)
                IDLE: begin
                    if (redirect_valid)
                        pc <= redirect_pc;
                    if (start)
                        state <= RUN;
                end
                RUN, FLUSH: begin
                    if (redirect_valid) begin
                        pc          <= redirect_pc;
                        out_valid   <= 1'b0;
                        fetch_fault <= 1'b0;
                        state       <= FLUSH;
                    end else if (state == FLUSH) begin
                        // One idle cycle lets a BTB write from the redirect land.
                        state <= RUN;
                    end else begin
                        if (capture) begin
                            out_valid         <= 1'b1;
                            out_addr_0        <= fetch_addr_0;
                            out_addr_1        <= fetch_addr_1;
                            out_instr_0       <= fetch_instr_0;
                            out_instr_1       <= fetch_instr_1;
                            out_instr_valid   <= fetch_valid;
                            out_pred_taken_0  <= fetch_pred_taken_0;
                            out_pred_taken_1  <= fetch_pred_taken_1;
                            out_pred_target_0 <= fetch_pred_target_0;
                            out_pred_target_1 <= fetch_pred_target_1;
                            pc                <= next_pc;
                        end else if (handshake) begin
                            out_valid <= 1'b0;
                        end
                        if (fetch_valid == 2'b00)
                            fetch_fault <= 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fetch_controller.sv
// Directed bench for fetch_controller with a bundle scoreboard checked at each
// decode handshake and inline checks of pc, counters and control outputs.
module tb_fetch_controller;

    localparam int AW = 32;
    localparam int DW = 32;
    localparam logic [31:0] XOR_KEY = 32'hDEAD_BEEF;

    typedef struct {
        logic [31:0] addr;
        logic [1:0]  valid;
    } bundle_t;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          start = 1'b0;
    logic [AW-1:0] pc;
    logic [AW-1:0] fetch_addr_0, fetch_addr_1;
    logic [DW-1:0] fetch_instr_0, fetch_instr_1;
    logic [1:0]    fetch_valid = 2'b11;
    logic          fetch_pred_taken_0 = 1'b0, fetch_pred_taken_1 = 1'b0;
    logic [AW-1:0] fetch_pred_target_0 = '0, fetch_pred_target_1 = '0;
    logic          redirect_valid = 1'b0;
    logic [AW-1:0] redirect_pc = '0;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic [AW-1:0] out_addr_0, out_addr_1;
    logic [DW-1:0] out_instr_0, out_instr_1;
    logic [1:0]    out_instr_valid;
    logic          out_pred_taken_0, out_pred_taken_1;
    logic [AW-1:0] out_pred_target_0, out_pred_target_1;
    logic          fetch_fault;
    logic [31:0]   instr_count;

    int      n_compared   = 0;
    int      n_mismatched = 0;
    bundle_t sb[$];

    // Fetch block model: slot addresses follow pc, instructions are address-derived.
    assign fetch_addr_0  = pc;
    assign fetch_addr_1  = pc + 32'd4;
    assign fetch_instr_0 = fetch_addr_0 ^ XOR_KEY;
    assign fetch_instr_1 = fetch_addr_1 ^ XOR_KEY;

    always #5 clk = ~clk;

    fetch_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .RESET_PC(32'h0)) dut (
        .clk(clk), .rst(rst), .start(start), .pc(pc),
        .fetch_addr_0(fetch_addr_0), .fetch_addr_1(fetch_addr_1),
        .fetch_instr_0(fetch_instr_0), .fetch_instr_1(fetch_instr_1),
        .fetch_valid(fetch_valid),
        .fetch_pred_taken_0(fetch_pred_taken_0), .fetch_pred_taken_1(fetch_pred_taken_1),
        .fetch_pred_target_0(fetch_pred_target_0), .fetch_pred_target_1(fetch_pred_target_1),
        .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
        .out_valid(out_valid), .out_ready(out_ready),
        .out_addr_0(out_addr_0), .out_addr_1(out_addr_1),
        .out_instr_0(out_instr_0), .out_instr_1(out_instr_1),
        .out_instr_valid(out_instr_valid),
        .out_pred_taken_0(out_pred_taken_0), .out_pred_taken_1(out_pred_taken_1),
        .out_pred_target_0(out_pred_target_0), .out_pred_target_1(out_pred_target_1),
        .fetch_fault(fetch_fault), .instr_count(instr_count)
    );

    // Handshake monitor: inputs change just after posedge, so mid-cycle values
    // are the ones the next edge will see.
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            n_compared++;
            if (sb.size() == 0) begin
                n_mismatched++;
                $display("FAIL sb_unexpected: bundle addr %h delivered, none expected", out_addr_0);
            end else begin
                bundle_t e;
                e = sb.pop_front();
                if (out_addr_0 !== e.addr || out_addr_1 !== e.addr + 32'd4 ||
                    out_instr_0 !== (e.addr ^ XOR_KEY) ||
                    out_instr_1 !== ((e.addr + 32'd4) ^ XOR_KEY) ||
                    out_instr_valid !== e.valid) begin
                    n_mismatched++;
                    $display("FAIL sb_bundle: got addr %h/%h instr %h/%h v %b, want addr %h v %b",
                             out_addr_0, out_addr_1, out_instr_0, out_instr_1,
                             out_instr_valid, e.addr, e.valid);
                end
            end
        end
    end

    task automatic step(input bit push, input logic [31:0] addr, input logic [1:0] v);
        bundle_t b;
        if (push) begin
            b.addr  = addr;
            b.valid = v;
            sb.push_back(b);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        #2;
        n_compared++;
        if (pc !== 32'h0 || out_valid !== 1'b0 || fetch_fault !== 1'b0 ||
            instr_count !== 32'h0 || out_addr_0 !== 32'h0 || out_instr_valid !== 2'b00) begin
            n_mismatched++;
            $display("FAIL reset: pc %h ov %b flt %b cnt %0d a0 %h iv %b, want all zero",
                     pc, out_valid, fetch_fault, instr_count, out_addr_0, out_instr_valid);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        // IDLE must not capture even with a valid fetch and a ready decode.
        out_ready = 1'b1;
        repeat (3) step(0, '0, '0);
        n_compared++;
        if (out_valid !== 1'b0 || pc !== 32'h0) begin
            n_mismatched++;
            $display("FAIL idle_hold: ov %b pc %h, want 0 / 0", out_valid, pc);
        end
    endtask

    task automatic test_sequential();
        start = 1'b1;
        step(0, '0, '0);
        start = 1'b0;
        n_compared++;
        if (pc !== 32'h0 || out_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL start_latency: pc %h ov %b, want 0 / 0", pc, out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            step(1, 32'(8 * i), 2'b11);
            n_compared++;
            if (pc !== 32'(8 * (i + 1)) || instr_count !== 32'(2 * i) || out_valid !== 1'b1) begin
                n_mismatched++;
                $display("FAIL seq_%0d: pc %h cnt %0d ov %b, want %h %0d 1",
                         i, pc, instr_count, out_valid, 32'(8 * (i + 1)), 2 * i);
            end
        end
        out_ready = 1'b0;
    endtask

    task automatic test_stall();
        for (int i = 0; i < 3; i++) begin
            step(0, '0, '0);
            n_compared++;
            if (pc !== 32'd32 || out_addr_0 !== 32'd24 || out_valid !== 1'b1 ||
                instr_count !== 32'd6) begin
                n_mismatched++;
                $display("FAIL stall_%0d: pc %h a0 %h ov %b cnt %0d, want 20 18 1 6",
                         i, pc, out_addr_0, out_valid, instr_count);
            end
        end
        out_ready = 1'b1;
        step(1, 32'd32, 2'b11);
        out_ready = 1'b0;
        n_compared++;
        if (pc !== 32'd40 || out_addr_0 !== 32'd32 || instr_count !== 32'd8) begin
            n_mismatched++;
            $display("FAIL stall_release: pc %h a0 %h cnt %0d, want 28 20 8",
                     pc, out_addr_0, instr_count);
        end
    endtask

    task automatic test_pred_taken_1();
        out_ready           = 1'b1;
        fetch_pred_taken_1  = 1'b1;
        fetch_pred_target_1 = 32'h100;
        step(1, 32'd40, 2'b11);
        out_ready          = 1'b0;
        fetch_pred_taken_1 = 1'b0;
        n_compared++;
        if (pc !== 32'h100 || out_pred_taken_1 !== 1'b1 || out_pred_target_1 !== 32'h100 ||
            instr_count !== 32'd10) begin
            n_mismatched++;
            $display("FAIL pred1: pc %h pt1 %b tgt1 %h cnt %0d, want 100 1 100 10",
                     pc, out_pred_taken_1, out_pred_target_1, instr_count);
        end
    endtask

    task automatic test_pred_taken_0();
        out_ready           = 1'b1;
        fetch_valid         = 2'b01;
        fetch_pred_taken_0  = 1'b1;
        fetch_pred_target_0 = 32'h40;
        step(1, 32'h100, 2'b01);
        fetch_valid        = 2'b11;
        fetch_pred_taken_0 = 1'b0;
        n_compared++;
        if (pc !== 32'h40 || out_instr_valid !== 2'b01 || out_pred_taken_0 !== 1'b1 ||
            instr_count !== 32'd12) begin
            n_mismatched++;
            $display("FAIL pred0: pc %h iv %b pt0 %b cnt %0d, want 40 01 1 12",
                     pc, out_instr_valid, out_pred_taken_0, instr_count);
        end
        step(1, 32'h40, 2'b11);
        out_ready = 1'b0;
        n_compared++;
        if (instr_count !== 32'd13 || pc !== 32'h48) begin
            n_mismatched++;
            $display("FAIL pred0_count: cnt %0d pc %h, want 13 48", instr_count, pc);
        end
    endtask

    task automatic test_redirect();
        // Redirect coincides with a handshake: the bundle still counts.
        out_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h200;
        step(0, '0, '0);
        redirect_valid = 1'b0;
        n_compared++;
        if (out_valid !== 1'b0 || pc !== 32'h200 || instr_count !== 32'd15) begin
            n_mismatched++;
            $display("FAIL redir_edge: ov %b pc %h cnt %0d, want 0 200 15",
                     out_valid, pc, instr_count);
        end
        step(0, '0, '0);
        n_compared++;
        if (out_valid !== 1'b0 || pc !== 32'h200) begin
            n_mismatched++;
            $display("FAIL redir_flush: ov %b pc %h, want 0 200", out_valid, pc);
        end
        step(1, 32'h200, 2'b11);
        out_ready = 1'b0;
        n_compared++;
        if (out_valid !== 1'b1 || out_addr_0 !== 32'h200 || pc !== 32'h208) begin
            n_mismatched++;
            $display("FAIL redir_first: ov %b a0 %h pc %h, want 1 200 208",
                     out_valid, out_addr_0, pc);
        end
    endtask

    task automatic test_double_redirect();
        bundle_t dropped;
        redirect_valid = 1'b1;
        redirect_pc    = 32'h280;
        step(0, '0, '0);
        dropped = sb.pop_front();
        redirect_pc = 32'h300;
        step(0, '0, '0);
        redirect_valid = 1'b0;
        out_ready      = 1'b1;
        n_compared++;
        if (pc !== 32'h300 || out_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL redir2_pc: pc %h ov %b (dropped %h), want 300 0",
                     pc, out_valid, dropped.addr);
        end
        step(0, '0, '0);
        n_compared++;
        if (out_valid !== 1'b0) begin
            n_mismatched++;
            $display("FAIL redir2_flush: ov %b, want 0", out_valid);
        end
        step(1, 32'h300, 2'b11);
        out_ready = 1'b0;
        n_compared++;
        if (out_addr_0 !== 32'h300 || out_valid !== 1'b1) begin
            n_mismatched++;
            $display("FAIL redir2_first: a0 %h ov %b, want 300 1", out_addr_0, out_valid);
        end
    endtask

    task automatic test_fault();
        fetch_valid = 2'b00;
        out_ready   = 1'b1;
        for (int i = 0; i < 2; i++) begin
            step(0, '0, '0);
            n_compared++;
            if (fetch_fault !== 1'b1 || pc !== 32'h308 || out_valid !== 1'b0 ||
                instr_count !== 32'd17) begin
                n_mismatched++;
                $display("FAIL fault_%0d: flt %b pc %h ov %b cnt %0d, want 1 308 0 17",
                         i, fetch_fault, pc, out_valid, instr_count);
            end
        end
        redirect_valid = 1'b1;
        redirect_pc    = 32'h400;
        step(0, '0, '0);
        redirect_valid = 1'b0;
        fetch_valid    = 2'b11;
        n_compared++;
        if (fetch_fault !== 1'b0 || pc !== 32'h400) begin
            n_mismatched++;
            $display("FAIL fault_clear: flt %b pc %h, want 0 400", fetch_fault, pc);
        end
    endtask

    task automatic test_async_reset();
        bundle_t dropped;
        out_ready = 1'b0;
        step(0, '0, '0);
        step(1, 32'h400, 2'b11);
        step(0, '0, '0);
        n_compared++;
        if (out_valid !== 1'b1 || pc !== 32'h408) begin
            n_mismatched++;
            $display("FAIL pre_reset_stall: ov %b pc %h, want 1 408", out_valid, pc);
        end
        #2;
        rst = 1'b1;
        #1;
        dropped = sb.pop_front();
        n_compared++;
        if (pc !== 32'h0 || out_valid !== 1'b0 || fetch_fault !== 1'b0 ||
            instr_count !== 32'h0 || out_addr_0 !== 32'h0 || out_instr_valid !== 2'b00) begin
            n_mismatched++;
            $display("FAIL async_reset: pc %h ov %b cnt %0d a0 %h (dropped %h), want zeros",
                     pc, out_valid, instr_count, out_addr_0, dropped.addr);
        end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_pred_taken_1();
        test_pred_taken_0();
        test_redirect();
        test_double_redirect();
        test_fault();
        test_async_reset();
        n_compared++;
        if (sb.size() != 0) begin
            n_mismatched++;
            $display("FAIL sb_leftover: %0d bundles never delivered, want 0", sb.size());
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule

// File: doc/fetch_controller.md
# fetch_controller

Front-end sequencer for the instruction fetch stage. Owns the architectural fetch PC, drives it into the instruction fetch block, and registers the returned two-instruction bundle and its BTB predictions into a one-entry output stage toward decode. Applies backpressure from decode, redirects from the branch and commit logic, and a start/fault protocol. It sits between the fetch block and the decode/rename front queue.

## Interface

Parameters:
- ADDR_WIDTH, 32, PC and address width
- DATA_WIDTH, 32, instruction width
- RESET_PC, 32'h0000_0000, PC loaded at reset

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-high reset
- start  in  1  leaves IDLE, sampled only in IDLE
- pc  out  ADDR_WIDTH  registered fetch PC to the fetch block
- fetch_addr_0, fetch_addr_1  in  ADDR_WIDTH  addresses of bundle slots 0/1, combinational from pc
- fetch_instr_0, fetch_instr_1  in  DATA_WIDTH  bundle instructions
- fetch_valid  in  2  slot valid bits; bit0 = slot 0
- fetch_pred_taken_0, fetch_pred_taken_1  in  1  BTB taken predictions
- fetch_pred_target_0, fetch_pred_target_1  in  ADDR_WIDTH  BTB targets
- redirect_valid  in  1  flush and restart request
- redirect_pc  in  ADDR_WIDTH  restart address
- out_valid  out  1  output bundle valid
- out_ready  in  1  decode accepts bundle
- out_addr_0, out_addr_1, out_instr_0, out_instr_1, out_instr_valid[1:0], out_pred_taken_0/1, out_pred_target_0/1  out  per fetch input  registered copy of the captured bundle
- fetch_fault  out  1  sticky: a fetch returned fetch_valid==2'b00
- instr_count  out  32  instructions delivered to decode

## Operation

- States: IDLE, RUN, FLUSH.
- IDLE: no capture. start=1 moves to RUN. redirect_valid loads pc and stays in IDLE.
- RUN, capture condition: fetch_valid[0]=1 and (out_valid=0 or out_ready=1) and redirect_valid=0.
- On capture:
  - Load all out_* registers from the fetch inputs.
  - Set out_valid=1.
  - Load pc with next_pc.
- next_pc priority:
  - fetch_valid[1] and pred_taken_1: pred_target_1
  - else fetch_valid[1]: fetch_addr_1+4
  - else pred_taken_0: pred_target_0
  - else pc+4
  - Additions are modulo 2^ADDR_WIDTH.
- Output handshake: out_valid and out_ready in the same cycle with no capture clears out_valid. Capture with out_ready high gives back-to-back transfer.
- Stall: out_valid=1 and out_ready=0. pc and all out_* registers hold.
- fetch_valid==2'b00 in RUN:
  - No capture and pc holds.
  - fetch_fault is set and stays set until the next redirect or reset.
- Redirect, in RUN or FLUSH:
  - pc loads redirect_pc.
  - out_valid clears; this discards a pending bundle even if out_ready was high.
  - fetch_fault clears.
  - State goes to FLUSH.
- FLUSH: lasts one cycle with no capture, so a BTB update written alongside the redirect is visible. Then the state goes to RUN. A redirect during FLUSH reloads pc and keeps the state in FLUSH.
- instr_count: on each handshake, adds popcount(out_instr_valid), 0–2. Wraps modulo 2^32. Redirect does not clear it.

## Timing

- Reset values:
  - state=IDLE, pc=RESET_PC
  - out_valid=0, all out_* data=0
  - fetch_fault=0, instr_count=0
- pc is registered. The fetch inputs are combinational from pc in the same cycle.
- Capture at edge E makes out_valid visible after E. Throughput is 1 bundle/cycle while out_ready=1.
- start sampled at edge E puts the state in RUN after E. The first capture is at edge E+1.
- Redirect sampled at edge E:
  - FLUSH during E→E+1.
  - First capture of the redirect_pc bundle at E+2.
  - Redirect-to-out_valid latency is 2 cycles.
- Redirect and handshake in the same cycle: the handshake counts toward instr_count, and out_valid clears.
- Reset asserted mid-operation: all state returns to reset values immediately, without waiting for clk.

## Test plan

- Reset, then start=1, out_ready=1, fetch_valid=2'b11, no predictions, RESET_PC=0 -> pc sequence 0, 8, 16 on consecutive cycles; instr_count=2, 4, 6.
- fetch_valid=2'b11, pred_taken_1=1, target_1=0x100 -> bundle captured, next pc=0x100.
- fetch_valid=2'b01, pred_taken_0=1, target_0=0x40 -> out_instr_valid=2'b01, next pc=0x40, instr_count +1.
- out_ready=0 for 3 cycles with out_valid=1 -> pc and out_* frozen. out_ready=1 -> one transfer, then capture resumes the following cycle.
- redirect_valid=1, redirect_pc=0x200 while out_valid=1 -> out_valid=0 next cycle, one FLUSH cycle, bundle for 0x200 valid two cycles after the redirect edge. A second redirect to 0x300 during FLUSH -> first bundle is from 0x300.
- fetch_valid=2'b00 in RUN -> fetch_fault=1, pc held. A redirect then clears the fault. Assert rst mid-stall -> all outputs at reset values asynchronously.
